vending_customer: RTL

VENDING_CUSTOMER -- requirements
Module: vending_customer

---
 rtl/vending_customer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vending_customer.sv
// Customer-side controller for a vending machine: takes one purchase order from the host,
// drives it into the machine, waits for the result, checks it and reports once.
module vending_customer #(
  parameter int unsigned TIMEOUT_CYCLES = 2047
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [23:0] reqCoins,
  input  logic [1:0]  reqItemType,
  input  logic [2:0]  reqItemNumber,
  input  logic        reqForce,
  output logic [23:0] coinIn,
  output logic [1:0]  itemTypeIn,
  output logic [2:0]  itemNumberIn,
  output logic        forceIn,
  input  logic [23:0] coinOut,
  input  logic [1:0]  itemTypeOut,
  input  logic [2:0]  itemNumberOut,
  input  logic [1:0]  serviceTypeOut,
  output logic        doneValid,
  output logic [2:0]  doneItems,
  output logic [12:0] doneChange,
  output logic        doneError,
  output logic        doneTimeout,
  output logic [1:0]  dbg_state
);

  // Handshake: an order transfers on a posedge where reqValid && reqReady; reqReady is high only in IDLE.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_OFF, REPORT} state_t;

  localparam logic [11:0] TIMEOUT_LIMIT = 12'(TIMEOUT_CYCLES);
  localparam logic [1:0]  SVC_OFF = 2'b00;
  localparam logic [1:0]  SVC_ON  = 2'b01;

  state_t      state;
  logic [23:0] order_coins;
  logic [1:0]  order_type;
  logic [2:0]  order_num;
  logic        order_force;
  logic [11:0] count;

  logic [12:0] in_value;
  logic [12:0] change_value;
  logic [12:0] item_cost;
  logic [12:0] spent;
  logic        check_ok;
  logic        timed_out;

  function automatic logic [12:0] coin_value(input logic [23:0] c);
    return 13'(c[23:18]) * 13'd50 + 13'(c[17:12]) * 13'd10 + 13'(c[11:6]) * 13'd5 + 13'(c[5:0]);
  endfunction

  always_comb begin
    item_cost = 13'd15;
    case (order_type)
      2'd0: item_cost = 13'd15;
      2'd1: item_cost = 13'd25;
      2'd2: item_cost = 13'd75;
      2'd3: item_cost = 13'd100;
      default: item_cost = 13'd15;
    endcase
  end

  // Worst case 700 + 4158 still fits in 13 bits, so the balance compare cannot wrap.
  assign in_value     = coin_value(order_coins);
  assign change_value = coin_value(coinOut);
  assign spent        = item_cost * 13'(itemNumberOut);
  assign check_ok     = (in_value == spent + change_value) &&
                        (itemTypeOut == order_type) &&
                        (itemNumberOut <= order_num) &&
                        (order_force || itemNumberOut == 3'd0 || itemNumberOut == order_num);
  assign timed_out    = (count == TIMEOUT_LIMIT);

  assign reqReady  = (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    coinIn       = '0;
    itemTypeIn   = '0;
    itemNumberIn = '0;
    forceIn      = 1'b0;
    if (state == ISSUE) begin
      coinIn       = order_coins;
      itemTypeIn   = order_type;
      itemNumberIn = order_num;
      forceIn      = order_force;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      order_coins <= '0;
      order_type  <= '0;
      order_num   <= '0;
      order_force <= 1'b0;
      doneValid   <= 1'b0;
      doneItems   <= '0;
      doneChange  <= '0;
      doneError   <= 1'b0;
      doneTimeout <= 1'b0;
    end else begin
      doneValid <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            order_coins <= reqCoins;
            order_type  <= reqItemType;
            order_num   <= reqItemNumber;
            order_force <= reqForce;
            count       <= '0;
            if (reqItemNumber == 3'd0) begin
              state       <= REPORT;
              doneValid   <= 1'b1;
              doneItems   <= '0;
              doneChange  <= '0;
              doneError   <= 1'b1;
              doneTimeout <= 1'b0;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (timed_out) begin
            state       <= REPORT;
            doneValid   <= 1'b1;
            doneItems   <= '0;
            doneChange  <= '0;
            doneError   <= 1'b1;
            doneTimeout <= 1'b1;
          end else begin
            count <= count + 12'd1;
            if (serviceTypeOut == SVC_ON) state <= WAIT_OFF;
          end
        end
        WAIT_OFF: begin
          // OFF wins over a timeout landing on the same edge.
          if (serviceTypeOut == SVC_OFF) begin
            state       <= REPORT;
            doneValid   <= 1'b1;
            doneItems   <= itemNumberOut;
            doneChange  <= change_value;
            doneError   <= !check_ok;
            doneTimeout <= 1'b0;
          end else if (timed_out) begin
            state       <= REPORT;
            doneValid   <= 1'b1;
            doneItems   <= '0;
            doneChange  <= '0;
            doneError   <= 1'b1;
            doneTimeout <= 1'b1;
          end else begin
            count <= count + 12'd1;
          end
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
